alu_exec_ctrl: RTL and testbench

ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

---
 rtl/alu_exec_ctrl.sv | 136 +++++++++++++
 tb/tb_alu_exec_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_ctrl.sv
// Execute/commit sequencer between decode and the register file, PC and status/stack registers.
// Latency: retire 2 cycles after accept, MULT_LAT+2 for MULT; one instruction in flight.
// Backpressure: issue_ready is high only while idle; kill aborts an instruction still in EXEC.
module alu_exec_ctrl #(
    parameter int MULT_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [5:0]  opcode,
    input  logic [2:0]  rd,
    input  logic        kill,
    input  logic [15:0] alu_res1,
    input  logic [15:0] alu_res2,
    input  logic [7:0]  alu_status,
    input  logic [11:0] alu_stack,
    output logic        reg_we,
    output logic [2:0]  reg_waddr,
    output logic [15:0] reg_wdata,
    output logic        pc_we,
    output logic [11:0] pc_wdata,
    output logic [7:0]  status_q,
    output logic [11:0] stack_q,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, EXEC, COMMIT, WB_HI} state_t;

    state_t      state, state_nx;
    logic [2:0]  cnt;
    logic [5:0]  op_q;
    logic [2:0]  rd_q;
    logic [15:0] res1_h, res2_h;
    logic [7:0]  status_h;
    logic [11:0] stack_h;

    logic       is_mult, is_jump, is_call, is_pop, no_wr, exec_last;
    logic [2:0] exec_len;

    always_comb begin
        is_mult   = (op_q == 6'b100001);
        is_jump   = (op_q == 6'b000000) || (op_q == 6'b100011) ||
                    (op_q == 6'b110111) || (op_q == 6'b111000);
        is_call   = (op_q == 6'b100100) || (op_q == 6'b100110) || (op_q == 6'b000011);
        is_pop    = (op_q == 6'b011011);
        no_wr     = (op_q == 6'b011100) || (op_q == 6'b001111) ||
                    (op_q >= 6'b101001 && op_q <= 6'b110110) ||
                    (op_q == 6'b010101) || (op_q == 6'b010110);
        exec_len  = is_mult ? 3'(MULT_LAT) : 3'd1;
        exec_last = (cnt == exec_len - 3'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (issue_valid && !kill) state_nx = EXEC;
            EXEC:    if (kill) state_nx = IDLE;
                     else if (exec_last) state_nx = COMMIT;
            COMMIT:  state_nx = is_mult ? WB_HI : IDLE;
            WB_HI:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, EXEC counting and architectural status/stack commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            res1_h   <= '0;
            res2_h   <= '0;
            status_h <= '0;
            stack_h  <= '0;
            status_q <= '0;
            stack_q  <= '0;
        end else begin
            if (state == IDLE && issue_valid && !kill) begin
                op_q <= opcode;
                rd_q <= rd;
                cnt  <= '0;
            end
            if (state == EXEC) begin
                cnt <= cnt + 3'd1;
                if (exec_last) begin
                    res1_h   <= alu_res1;
                    res2_h   <= alu_res2;
                    status_h <= alu_status;
                    stack_h  <= alu_stack;
                end
            end
            if (state == COMMIT) begin
                status_q <= status_h;
                if (is_call || is_pop) stack_q <= stack_h;
            end
        end
    end

    always_comb begin
        issue_ready = (state == IDLE);
        reg_we      = 1'b0;
        reg_waddr   = '0;
        reg_wdata   = '0;
        pc_we       = 1'b0;
        pc_wdata    = '0;
        done        = 1'b0;
        case (state)
            COMMIT: begin
                done = !is_mult;
                if (is_jump || is_call) begin
                    pc_we    = 1'b1;
                    pc_wdata = res1_h[11:0];
                end else if (!no_wr) begin
                    reg_we    = 1'b1;
                    reg_waddr = rd_q;
                    reg_wdata = res1_h;
                end
            end
            WB_HI: begin
                // High product word goes to the next register up, wrapping 7 -> 0.
                done      = 1'b1;
                reg_we    = 1'b1;
                reg_waddr = rd_q + 3'd1;
                reg_wdata = res2_h;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: opcode vector table plus kill/reset sequences,
// with a write scoreboard checked at the negative clock edge.
module tb_alu_exec_ctrl;

    localparam int MULT_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, issue_ready, kill;
    logic [5:0]  opcode;
    logic [2:0]  rd;
    logic [15:0] alu_res1, alu_res2;
    logic [7:0]  alu_status;
    logic [11:0] alu_stack;
    logic        reg_we, pc_we, done;
    logic [2:0]  reg_waddr;
    logic [15:0] reg_wdata;
    logic [11:0] pc_wdata, stack_q;
    logic [7:0]  status_q;

    alu_exec_ctrl #(.MULT_LAT(MULT_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .opcode(opcode), .rd(rd), .kill(kill), .alu_res1(alu_res1), .alu_res2(alu_res2),
        .alu_status(alu_status), .alu_stack(alu_stack), .reg_we(reg_we), .reg_waddr(reg_waddr),
        .reg_wdata(reg_wdata), .pc_we(pc_we), .pc_wdata(pc_wdata), .status_q(status_q),
        .stack_q(stack_q), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
        int          at;
    } wr_t;

    wr_t rq[$];
    wr_t pq[$];
    int  dq[$];

    // Writes are compared when they appear; 'at' is the edge that captures them.
    always @(negedge clk) begin
        wr_t w;
        if (rst_n) begin
            if (reg_we) begin
                if (rq.size() == 0) chk("unexpected reg_we", 32'(reg_we), 32'd0);
                else begin
                    w = rq.pop_front();
                    chk("reg_waddr", 32'(reg_waddr), 32'(w.a));
                    chk("reg_wdata", 32'(reg_wdata), 32'(w.d));
                    chk("reg_we edge", 32'(cyc + 1), 32'(w.at));
                end
            end
            if (pc_we) begin
                if (pq.size() == 0) chk("unexpected pc_we", 32'(pc_we), 32'd0);
                else begin
                    w = pq.pop_front();
                    chk("pc_wdata", 32'(pc_wdata), 32'(w.d));
                    chk("pc_we edge", 32'(cyc + 1), 32'(w.at));
                end
            end
            if (done) begin
                if (dq.size() == 0) chk("unexpected done", 32'(done), 32'd0);
                else chk("done edge", 32'(cyc + 1), 32'(dq.pop_front()));
            end
        end
    end

    typedef struct {
        logic [5:0]  op;
        logic [2:0]  rd;
        logic [15:0] r1, r2;
        logic [7:0]  st;
        logic [11:0] sk;
        bit          e_reg, e_pc, e_stk, e_hi;
        int          e_lat;
    } vec_t;

    logic [7:0]  exp_status = 8'h00;
    logic [11:0] exp_stack  = 12'h000;

    // Starts #1 after a rising edge with the controller idle; kill_at >= 0 pulses
    // kill that many edges after the accept edge; expect=0 means nothing retires.
    task automatic run_op(input vec_t v, input int kill_at, input bit expect_ret);
        int a;
        int n;
        wr_t w;
        issue_valid = 1'b1;
        opcode = v.op; rd = v.rd; alu_res1 = v.r1; alu_res2 = v.r2;
        alu_status = v.st; alu_stack = v.sk;
        @(posedge clk); #1;
        issue_valid = 1'b0;
        a = cyc;
        chk("issue_ready busy", 32'(issue_ready), 32'd0);
        if (expect_ret) begin
            if (v.e_reg) begin
                w.a = v.rd; w.d = v.r1; w.at = v.e_hi ? a + v.e_lat - 1 : a + v.e_lat;
                rq.push_back(w);
            end
            if (v.e_hi) begin
                w.a = v.rd + 3'd1; w.d = v.r2; w.at = a + v.e_lat;
                rq.push_back(w);
            end
            if (v.e_pc) begin
                w.a = '0; w.d = {4'h0, v.r1[11:0]}; w.at = a + v.e_lat;
                pq.push_back(w);
            end
            dq.push_back(a + v.e_lat);
        end
        n = 0;
        kill = (kill_at == 0);
        while (!issue_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
            kill = (n == kill_at);
        end
        kill = 1'b0;
        if (!issue_ready) chk("timeout waiting for idle", 32'(issue_ready), 32'd1);
        if (expect_ret) begin
            exp_status = v.st;
            if (v.e_stk) exp_stack = v.sk;
        end
        chk("status_q", 32'(status_q), 32'(exp_status));
        chk("stack_q", 32'(stack_q), 32'(exp_stack));
    endtask

    vec_t tbl[15];
    vec_t k;

    initial begin
        //          op         rd    r1        r2        st     sk       reg pc stk hi lat
        tbl[0]  = '{6'b010001, 3'd3, 16'h1234, 16'h0000, 8'h11, 12'h000, 1, 0, 0, 0, 2};
        tbl[1]  = '{6'b100001, 3'd7, 16'h0001, 16'hFFFE, 8'h22, 12'h000, 1, 0, 0, 1, MULT_LAT + 2};
        tbl[2]  = '{6'b100100, 3'd1, 16'h0ABC, 16'h0000, 8'h33, 12'h005, 0, 1, 1, 0, 2};
        tbl[3]  = '{6'b101101, 3'd2, 16'h7777, 16'h0000, 8'h44, 12'h0FF, 0, 0, 0, 0, 2};
        tbl[4]  = '{6'b000000, 3'd4, 16'hF123, 16'h0000, 8'h55, 12'h0EE, 0, 1, 0, 0, 2};
        tbl[5]  = '{6'b011011, 3'd5, 16'hBEEF, 16'h0000, 8'h66, 12'h7FF, 1, 0, 1, 0, 2};
        tbl[6]  = '{6'b011100, 3'd6, 16'hAAAA, 16'h0000, 8'h77, 12'h111, 0, 0, 0, 0, 2};
        tbl[7]  = '{6'b100110, 3'd0, 16'h0456, 16'h0000, 8'h88, 12'hABC, 0, 1, 1, 0, 2};
        tbl[8]  = '{6'b010101, 3'd1, 16'h1111, 16'h0000, 8'h99, 12'h222, 0, 0, 0, 0, 2};
        tbl[9]  = '{6'b101001, 3'd2, 16'h2222, 16'h0000, 8'hA1, 12'h333, 0, 0, 0, 0, 2};
        tbl[10] = '{6'b110110, 3'd3, 16'h3333, 16'h0000, 8'hA2, 12'h444, 0, 0, 0, 0, 2};
        tbl[11] = '{6'b110111, 3'd4, 16'h0FED, 16'h0000, 8'hA3, 12'h555, 0, 1, 0, 0, 2};
        tbl[12] = '{6'b101000, 3'd5, 16'hC0DE, 16'h0000, 8'hA4, 12'h666, 1, 0, 0, 0, 2};
        tbl[13] = '{6'b100001, 3'd2, 16'hAAAA, 16'h5555, 8'hA5, 12'h777, 1, 0, 0, 1, MULT_LAT + 2};
        tbl[14] = '{6'b000011, 3'd6, 16'h0321, 16'h0000, 8'hA6, 12'h0CA, 0, 1, 1, 0, 2};

        rst_n = 1'b0; issue_valid = 1'b0; kill = 1'b0;
        opcode = '0; rd = '0; alu_res1 = '0; alu_res2 = '0; alu_status = '0; alu_stack = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset issue_ready", 32'(issue_ready), 32'd1);
        chk("reset reg_we", 32'(reg_we), 32'd0);
        chk("reset pc_we", 32'(pc_we), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset status_q", 32'(status_q), 32'd0);
        chk("reset stack_q", 32'(stack_q), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) run_op(tbl[i], -1, 1'b1);

        // Kill during EXEC of a MULT: nothing retires.
        k = '{6'b100001, 3'd1, 16'h1357, 16'h2468, 8'hEE, 12'hFED, 1, 0, 0, 1, MULT_LAT + 2};
        run_op(k, 0, 1'b0);
        run_op(k, 1, 1'b0);
        chk("after kill reg_we", 32'(reg_we), 32'd0);

        // Kill arriving in COMMIT or WB_HI is too late to stop retirement.
        k = '{6'b010010, 3'd1, 16'h0F0F, 16'h0000, 8'h5A, 12'h000, 1, 0, 0, 0, 2};
        run_op(k, 1, 1'b1);
        k = '{6'b100001, 3'd7, 16'h1000, 16'h2000, 8'h5B, 12'h000, 1, 0, 0, 1, MULT_LAT + 2};
        run_op(k, MULT_LAT + 1, 1'b1);

        // Kill and issue together in IDLE: no accept.
        issue_valid = 1'b1; kill = 1'b1; opcode = 6'b010001;
        @(posedge clk); #1;
        chk("kill beats issue", 32'(issue_ready), 32'd1);
        issue_valid = 1'b0; kill = 1'b0;
        @(posedge clk); #1;
        chk("still idle", 32'(issue_ready), 32'd1);

        // Reset while the MULT high word is being written.
        begin
            int a;
            wr_t w;
            issue_valid = 1'b1; opcode = 6'b100001; rd = 3'd4;
            alu_res1 = 16'h1111; alu_res2 = 16'h2222; alu_status = 8'h99; alu_stack = 12'h321;
            @(posedge clk); #1;
            issue_valid = 1'b0;
            a = cyc;
            w.a = 3'd4; w.d = 16'h1111; w.at = a + MULT_LAT + 1;
            rq.push_back(w);
            repeat (MULT_LAT + 1) @(posedge clk);
            #1;
            chk("wb_hi reg_we", 32'(reg_we), 32'd1);
            chk("wb_hi waddr", 32'(reg_waddr), 32'd5);
            rst_n = 1'b0;
            #1;
            chk("rst reg_we", 32'(reg_we), 32'd0);
            chk("rst waddr", 32'(reg_waddr), 32'd0);
            chk("rst wdata", 32'(reg_wdata), 32'd0);
            chk("rst done", 32'(done), 32'd0);
            chk("rst pc", 32'({pc_we, pc_wdata}), 32'd0);
            chk("rst status_q", 32'(status_q), 32'd0);
            chk("rst stack_q", 32'(stack_q), 32'd0);
            chk("rst issue_ready", 32'(issue_ready), 32'd1);
            @(posedge clk); #1;
            rst_n = 1'b1;
            exp_status = 8'h00; exp_stack = 12'h000;
            @(posedge clk); #1;
        end

        run_op(tbl[0], -1, 1'b1);

        repeat (3) @(posedge clk);
        chk("pending reg writes", 32'(rq.size()), 32'd0);
        chk("pending pc writes", 32'(pq.size()), 32'd0);
        chk("pending done", 32'(dq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
